// File: rtl/cos_pkg.sv
// Shared constants for the time-shared cosine generator and its scheduler.
package cos_pkg;

    localparam int COS_LAT = 6;
    localparam int COS_NBA = 26;
    localparam int COS_NBD = 23;

    // A quarter turn in phase units: 2^(nba-2).
    function automatic longint unsigned qturn(input int nba);
        return 64'd1 << (nba - 2);
    endfunction

endpackage

// File: rtl/cos_rr_arb.sv
// Round-robin grant selection: searches from ptr+1 upward (mod NCH), first valid requester wins.
module cos_rr_arb #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic [NCH-1:0]         gnt,
    output logic [$clog2(NCH)-1:0] idx,
    output logic                   any
);

    localparam int CW = $clog2(NCH);

    int sel;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        sel = 0;
        for (int k = 1; k <= NCH; k++) begin
            sel = (int'(ptr) + k) % NCH;
            if (!any && req[sel]) begin
                any      = 1'b1;
                gnt[sel] = 1'b1;
                idx      = CW'(sel);
            end
        end
    end

endmodule

// File: rtl/cos_sched.sv
// Shares one fixed-latency cosine generator among NCH requesters; tags carry each
// issued phase's owner through the generator latency and steer the result back.
module cos_sched
    import cos_pkg::*;
#(
    parameter int NCH = 4,
    parameter int NBA = COS_NBA,
    parameter int NBD = COS_NBD,
    parameter int LAT = COS_LAT
) (
    input  logic                         c,
    input  logic                         rst_n,
    input  logic [NCH-1:0]               req_valid,
    input  logic [NCH-1:0]               req_sin,
    input  logic [NCH*NBA-1:0]           req_phase,
    output logic [NCH-1:0]               req_ready,
    output logic [NBA-1:0]               gen_a,
    input  logic signed [NBD-1:0]        gen_o,
    output logic [NCH-1:0]               out_valid,
    output logic [NCH*NBD-1:0]           out_data,
    output logic [$clog2(LAT+2)-1:0]     inflight
);

    localparam int CW = $clog2(NCH);
    localparam int IW = $clog2(LAT + 2);
    localparam logic [NBA-1:0] QT = NBA'(qturn(NBA));

    // sin(x) = cos(x - quarter turn); the subtraction wraps modulo full scale.
    function automatic logic [NBA-1:0] cos_phase(input logic [NBA-1:0] ph, input logic sin);
        return sin ? ph - QT : ph;
    endfunction

    logic [NCH-1:0] gnt;
    logic [CW-1:0]  idx;
    logic           any;
    logic [CW-1:0]  ptr;

    // Holding requests out of the arbiter during reset keeps req_ready low.
    cos_rr_arb #(.NCH(NCH)) u_arb (
        .req (req_valid & {NCH{rst_n}}),
        .ptr (ptr),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    assign req_ready = gnt;

    // Stage p0: grant edge, phase issue and pointer update
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= CW'(NCH - 1);
            gen_a <= '0;
        end else if (any) begin
            ptr   <= idx;
            gen_a <= cos_phase(req_phase[int'(idx)*NBA +: NBA], req_sin[idx]);
        end
    end

    logic          tag_vld [0:LAT];
    logic [CW-1:0] tag_ch  [0:LAT];
    logic          ret;
    logic [CW-1:0] ret_ch;

    // Stages p0..pLAT: tag shift matched to generator latency
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LAT; k++) begin
                tag_vld[k] <= 1'b0;
                tag_ch[k]  <= '0;
            end
        end else begin
            tag_vld[0] <= any;
            tag_ch[0]  <= idx;
            for (int k = 1; k <= LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_ch[k]  <= tag_ch[k-1];
            end
        end
    end

    assign ret    = tag_vld[LAT];
    assign ret_ch = tag_ch[LAT];

    // Stage pLAT+1: return decode into the per-channel result registers
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= '0;
            if (ret) begin
                out_valid[ret_ch]                   <= 1'b1;
                out_data[int'(ret_ch)*NBD +: NBD]   <= gen_o;
            end
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            unique case ({any, ret})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule
